// File: rtl/scheduler_sram_ctrl_if.sv
// Bundles the scheduler controller's packet, SRAM and row-delivery signals.
// The controller attaches through the slave modport; the surrounding fabric uses master.
interface scheduler_sram_ctrl_if #(
    parameter int unsigned NUM_AXONS = 256,
    parameter int unsigned NUM_TICKS = 16
);
    localparam int unsigned AW = $clog2(NUM_AXONS);
    localparam int unsigned TW = $clog2(NUM_TICKS);

    logic                 tick;
    logic                 pkt_a_valid;
    logic                 pkt_a_ready;
    logic [AW+TW-1:0]     pkt_a_data;
    logic                 pkt_b_valid;
    logic                 pkt_b_ready;
    logic [AW+TW-1:0]     pkt_b_data;
    logic                 sram_wen;
    logic                 sram_clr;
    logic [TW-1:0]        sram_read_addr;
    logic [AW+TW-1:0]     sram_packet;
    logic [NUM_AXONS-1:0] sram_out;
    logic                 row_valid;
    logic                 row_ready;
    logic [NUM_AXONS-1:0] row_data;
    logic                 tick_overrun;
    logic                 pkt_drop;

    modport slave (
        input  tick,
        input  pkt_a_valid,
        output pkt_a_ready,
        input  pkt_a_data,
        input  pkt_b_valid,
        output pkt_b_ready,
        input  pkt_b_data,
        output sram_wen,
        output sram_clr,
        output sram_read_addr,
        output sram_packet,
        input  sram_out,
        output row_valid,
        input  row_ready,
        output row_data,
        output tick_overrun,
        output pkt_drop
    );

    modport master (
        output tick,
        output pkt_a_valid,
        input  pkt_a_ready,
        output pkt_a_data,
        output pkt_b_valid,
        input  pkt_b_ready,
        output pkt_b_data,
        input  sram_wen,
        input  sram_clr,
        input  sram_read_addr,
        input  sram_packet,
        output sram_out,
        input  row_valid,
        output row_ready,
        input  row_data,
        input  tick_overrun,
        input  pkt_drop
    );
endinterface

// File: rtl/scheduler_sram_ctrl.sv
// Scheduler SRAM sequencer: arbitrates spike packets from two sources into row writes
// and walks the tick pointer through present / clear / advance once per global tick.
module scheduler_sram_ctrl #(
    parameter int unsigned NUM_AXONS = 256,
    parameter int unsigned NUM_TICKS = 16
) (
    input logic                  clk,
    input logic                  rst,
    scheduler_sram_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(NUM_AXONS);
    localparam int unsigned TW = $clog2(NUM_TICKS);
    localparam logic [TW-1:0] LAST_TICK = TW'(NUM_TICKS - 1);

    typedef enum logic [1:0] {StInit, StIdle, StRow, StClear} state_e;

    state_e           r_state, w_state_next;
    logic [TW-1:0]    r_init_cnt, w_init_cnt_next;
    logic [TW-1:0]    r_read_addr, w_read_addr_next;
    logic             r_prefer_b, w_prefer_b_next;
    logic             r_wen, w_wen_next;
    logic [AW+TW-1:0] r_packet, w_packet_next;
    logic             r_tick_overrun, w_tick_overrun_next;
    logic             r_pkt_drop, w_pkt_drop_next;

    logic             w_accept_window;
    logic             w_grant_b;
    logic             w_accept;
    logic             w_alias;
    logic [AW+TW-1:0] w_acc_data;

    // B wins only when it is the sole requester or A was served last.
    always_comb begin
        w_accept_window = (r_state == StIdle) && !bus.tick;
        w_grant_b       = bus.pkt_b_valid && (!bus.pkt_a_valid || r_prefer_b);
        w_accept        = w_accept_window && (w_grant_b ? bus.pkt_b_valid : bus.pkt_a_valid);
        w_acc_data      = w_grant_b ? bus.pkt_b_data : bus.pkt_a_data;
        w_alias         = (w_acc_data[TW-1:0] == LAST_TICK);
    end

    always_comb begin
        w_state_next        = r_state;
        w_init_cnt_next     = r_init_cnt;
        w_read_addr_next    = r_read_addr;
        w_prefer_b_next     = r_prefer_b;
        w_wen_next          = 1'b0;
        w_packet_next       = r_packet;
        w_tick_overrun_next = r_tick_overrun;
        w_pkt_drop_next     = r_pkt_drop;

        if (w_accept) begin
            w_prefer_b_next = !w_grant_b;
            w_packet_next   = w_acc_data;
            // Maximum delay would land on the row currently being consumed.
            w_wen_next      = !w_alias;
            if (w_alias) begin
                w_pkt_drop_next = 1'b1;
            end
        end

        if (bus.tick && (r_state == StRow || r_state == StClear)) begin
            w_tick_overrun_next = 1'b1;
        end

        unique case (r_state)
            StInit: begin
                w_init_cnt_next = r_init_cnt + TW'(1);
                if (r_init_cnt == LAST_TICK) begin
                    w_state_next = StIdle;
                end
            end
            StIdle: begin
                if (bus.tick) begin
                    w_state_next = StRow;
                end
            end
            StRow: begin
                if (bus.row_ready) begin
                    w_state_next = StClear;
                end
            end
            StClear: begin
                w_read_addr_next = r_read_addr + TW'(1);
                w_state_next     = StIdle;
            end
            default: w_state_next = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= StInit;
            r_init_cnt     <= '0;
            r_read_addr    <= '0;
            r_prefer_b     <= 1'b0;
            r_wen          <= 1'b0;
            r_packet       <= '0;
            r_tick_overrun <= 1'b0;
            r_pkt_drop     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_init_cnt     <= w_init_cnt_next;
            r_read_addr    <= w_read_addr_next;
            r_prefer_b     <= w_prefer_b_next;
            r_wen          <= w_wen_next;
            r_packet       <= w_packet_next;
            r_tick_overrun <= w_tick_overrun_next;
            r_pkt_drop     <= w_pkt_drop_next;
        end
    end

    assign bus.pkt_a_ready    = w_accept_window && !w_grant_b;
    assign bus.pkt_b_ready    = w_accept_window && w_grant_b;
    assign bus.sram_wen       = r_wen;
    assign bus.sram_clr       = (r_state == StClear);
    assign bus.sram_read_addr = r_read_addr;
    assign bus.sram_packet    = r_packet;
    assign bus.row_valid      = (r_state == StRow);
    assign bus.row_data       = bus.sram_out;
    assign bus.tick_overrun   = r_tick_overrun;
    assign bus.pkt_drop       = r_pkt_drop;
endmodule

// File: tb/tb_scheduler_sram_ctrl.sv
// Directed bench for scheduler_sram_ctrl with a behavioural scheduler SRAM
// (write row = delay + pointer + 1, clear current row on sram_clr).
module tb_scheduler_sram_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    scheduler_sram_ctrl_if #(.NUM_AXONS(256), .NUM_TICKS(16)) bus ();

    scheduler_sram_ctrl #(.NUM_AXONS(256), .NUM_TICKS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [255:0] mem [16];
    logic [3:0]   w_wr_row;
    assign w_wr_row     = bus.sram_packet[3:0] + bus.sram_read_addr + 4'd1;
    assign bus.sram_out = mem[bus.sram_read_addr];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (bus.sram_wen) mem[w_wr_row][bus.sram_packet[11:4]] <= 1'b1;
            if (bus.sram_clr) mem[bus.sram_read_addr] <= '0;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input logic [3:0] addr, input logic [255:0] row);
        logic [3:0] nxt;
        nxt = addr + 4'd1;
        bus.tick = 1'b1;
        #1;
        chk("tick_no_ready_a", 256'(bus.pkt_a_ready), 256'(0));
        cyc();
        bus.tick = 1'b0;
        #1;
        chk("row_valid", 256'(bus.row_valid), 256'(1));
        chk("row_addr", 256'(bus.sram_read_addr), 256'(addr));
        chk("row_data", bus.row_data, row);
        cyc();
        chk("clr_on", 256'(bus.sram_clr), 256'(1));
        chk("clr_no_wen", 256'(bus.sram_wen), 256'(0));
        cyc();
        chk("clr_off", 256'(bus.sram_clr), 256'(0));
        chk("ptr_adv", 256'(bus.sram_read_addr), 256'(nxt));
    endtask

    initial begin
        logic [11:0]  pa;
        logic [11:0]  pb;
        logic [255:0] row3;
        logic [255:0] row5;
        logic [3:0]   a;
        n_checks = 0;
        n_errors = 0;
        pa   = {8'd5, 4'd2};
        pb   = {8'd20, 4'd4};
        row3 = '0;
        row3[5] = 1'b1;
        row5 = '0;
        row5[20] = 1'b1;

        rst = 1'b0;
        bus.tick = 1'b0;
        bus.pkt_a_valid = 1'b0;
        bus.pkt_a_data = '0;
        bus.pkt_b_valid = 1'b0;
        bus.pkt_b_data = '0;
        bus.row_ready = 1'b1;
        cyc();
        cyc();
        chk("rst_ready_a", 256'(bus.pkt_a_ready), 256'(0));
        chk("rst_ready_b", 256'(bus.pkt_b_ready), 256'(0));
        chk("rst_wen", 256'(bus.sram_wen), 256'(0));
        chk("rst_clr", 256'(bus.sram_clr), 256'(0));
        chk("rst_addr", 256'(bus.sram_read_addr), 256'(0));
        chk("rst_row_valid", 256'(bus.row_valid), 256'(0));
        chk("rst_overrun", 256'(bus.tick_overrun), 256'(0));
        chk("rst_drop", 256'(bus.pkt_drop), 256'(0));

        // Both sources valid from the first post-reset cycle; INIT blocks them for 16 cycles.
        bus.pkt_a_valid = 1'b1;
        bus.pkt_a_data  = pa;
        bus.pkt_b_valid = 1'b1;
        bus.pkt_b_data  = pb;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            chk("init_ready_a", 256'(bus.pkt_a_ready), 256'(0));
            cyc();
        end

        for (int i = 0; i < 6; i++) begin
            chk("rr_ready_a", 256'(bus.pkt_a_ready), 256'(i % 2 == 0));
            chk("rr_ready_b", 256'(bus.pkt_b_ready), 256'(i % 2 == 1));
            if (i > 0) begin
                chk("rr_wen", 256'(bus.sram_wen), 256'(1));
                chk("rr_packet", 256'(bus.sram_packet), 256'((i % 2 == 1) ? pa : pb));
            end
            cyc();
        end
        bus.pkt_a_valid = 1'b0;
        bus.pkt_b_valid = 1'b0;
        #1;
        chk("rr_last_wen", 256'(bus.sram_wen), 256'(1));
        chk("rr_last_packet", 256'(bus.sram_packet), 256'(pb));
        cyc();
        chk("wen_single", 256'(bus.sram_wen), 256'(0));

        do_tick(4'd0, '0);
        do_tick(4'd1, '0);
        do_tick(4'd2, '0);
        do_tick(4'd3, row3);

        // Stalled row with a second tick arriving during the stall.
        bus.row_ready = 1'b0;
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        #1;
        chk("stall_valid1", 256'(bus.row_valid), 256'(1));
        chk("stall_no_ovr", 256'(bus.tick_overrun), 256'(0));
        chk("stall_row", bus.row_data, '0);
        cyc();
        bus.tick = 1'b1;
        #1;
        chk("stall_valid2", 256'(bus.row_valid), 256'(1));
        cyc();
        bus.tick = 1'b0;
        #1;
        chk("stall_overrun", 256'(bus.tick_overrun), 256'(1));
        chk("stall_valid3", 256'(bus.row_valid), 256'(1));
        chk("stall_no_clr", 256'(bus.sram_clr), 256'(0));
        cyc();
        chk("stall_valid4", 256'(bus.row_valid), 256'(1));
        cyc();
        bus.row_ready = 1'b1;
        #1;
        chk("stall_release", 256'(bus.row_valid), 256'(1));
        chk("stall_clr_wait", 256'(bus.sram_clr), 256'(0));
        cyc();
        chk("stall_clr", 256'(bus.sram_clr), 256'(1));
        chk("stall_clr_rv", 256'(bus.row_valid), 256'(0));
        cyc();
        chk("stall_clr_off", 256'(bus.sram_clr), 256'(0));
        chk("stall_ptr", 256'(bus.sram_read_addr), 256'(5));

        for (int i = 0; i < 16; i++) begin
            a = 4'(5 + i);
            do_tick(a, (i == 0) ? row5 : 256'(0));
        end

        // Delay 15 aliases onto the current row: handshake completes, write suppressed.
        bus.pkt_a_valid = 1'b1;
        bus.pkt_a_data  = {8'd7, 4'd15};
        #1;
        chk("drop_ready", 256'(bus.pkt_a_ready), 256'(1));
        cyc();
        bus.pkt_a_valid = 1'b0;
        #1;
        chk("drop_no_wen", 256'(bus.sram_wen), 256'(0));
        chk("drop_flag", 256'(bus.pkt_drop), 256'(1));
        cyc();
        chk("drop_sticky", 256'(bus.pkt_drop), 256'(1));
        chk("drop_no_wen2", 256'(bus.sram_wen), 256'(0));

        // Reset in the middle of a presented row.
        bus.row_ready = 1'b0;
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        #1;
        chk("mid_row_valid", 256'(bus.row_valid), 256'(1));
        chk("mid_overrun_held", 256'(bus.tick_overrun), 256'(1));
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        chk("mrst_row_valid", 256'(bus.row_valid), 256'(0));
        chk("mrst_addr", 256'(bus.sram_read_addr), 256'(0));
        chk("mrst_drop", 256'(bus.pkt_drop), 256'(0));
        chk("mrst_overrun", 256'(bus.tick_overrun), 256'(0));
        chk("mrst_ready_a", 256'(bus.pkt_a_ready), 256'(0));
        chk("mrst_clr", 256'(bus.sram_clr), 256'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
